spi_byte_framer: RTL and testbench

//  SPI slave front end (mode 0, MSB first) in the CLK domain. Feeds the address pointer stage.

---
 rtl/pwm_io_pkg.sv | 18 +
 rtl/sync_edge_detect.sv | 37 +++
 rtl/spi_byte_framer.sv | 194 +++++++++++++++++++
 tb/tb_spi_byte_framer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_io_pkg.sv
// Shared types and constants for the SPI byte framer and its pointer/register-file neighbours.
package pwm_io_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ADDR      = 2'd2,
    DATA      = 2'd3
  } framer_state_t;

  // CLK must run at least this many times faster than SCLK.
  localparam int SPI_MIN_CLK_RATIO = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pin with registered rise/fall pulses.
// Pin-to-pulse latency is Stages+1 CLK cycles; the synced level lags the pin by Stages cycles.
module sync_edge_detect #(
  parameter int Stages = 2
) (
  input  logic CLK,
  input  logic _RST,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      prev_q <= sync_q[Stages-1];
      rise_q <= sync_q[Stages-1] & ~prev_q;
      fall_q <= ~sync_q[Stages-1] & prev_q;
    end
  end

  assign sync_o = sync_q[Stages-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_byte_framer.sv
// SPI mode-0 slave front end: frames each _CS-low transaction as an address byte plus data bytes.
// Optional readback path (MISO/ReadData) is enabled by defining SPI_READBACK_EN.
module spi_byte_framer
  import pwm_io_pkg::*;
#(
  parameter int AddressWidth = 8,
  parameter int DataWidth    = 8,
  parameter int SyncStages   = 2
) (
  input  logic                    CLK,
  input  logic                    _RST,
  input  logic                    SCLK,
  input  logic                    MOSI,
  input  logic                    _CS,
  output logic                    FirstByteReceived,
  output logic [AddressWidth-1:0] FirstAddress,
  output logic [DataWidth-1:0]    WriteData,
  output logic                    WriteStrobe,
  output logic                    AddressStep,
  output logic                    FrameError
`ifdef SPI_READBACK_EN
  ,
  input  logic [DataWidth-1:0]    ReadData,
  output logic                    MISO
`endif
);

  localparam int SW = max_int(AddressWidth, DataWidth);
  localparam int CW = $clog2(SW + 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(AddressWidth - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DataWidth - 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic [SyncStages-1:0] mosi_sync_q;
  logic mosi_s;

  sync_edge_detect #(.Stages(SyncStages)) u_sclk_sync (
    .CLK    (CLK),
    ._RST   (_RST),
    .d_i    (SCLK),
    .sync_o (sclk_sync),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge_detect #(.Stages(SyncStages)) u_cs_sync (
    .CLK    (CLK),
    ._RST   (_RST),
    .d_i    (_CS),
    .sync_o (cs_sync),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // MOSI is one stage ahead of the SCLK rise pulse, so it is already stable when sampled.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], MOSI};
    end
  end

  assign mosi_s = mosi_sync_q[SyncStages-1];

  framer_state_t           state_q, state_d;
  logic [CW-1:0]           bitcnt_q, bitcnt_d;
  logic [SW-2:0]           shift_q, shift_d;
  logic [SW-1:0]           full_shift;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic                    fbr_q, fbr_d;
  logic                    strobe_q, strobe_d;
  logic                    step_q, step_d;
  logic                    ferr_q, ferr_d;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fbr_d      = fbr_q;
    strobe_d   = 1'b0;
    step_d     = strobe_q;
    ferr_d     = 1'b0;
    full_shift = {shift_q, mosi_s};

    case (state_q)
      WAIT_IDLE: begin
        if (cs_sync) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          state_d  = ADDR;
          bitcnt_d = '0;
        end
      end
      ADDR, DATA: begin
        // A _CS rise takes priority over any SCLK edge seen in the same cycle.
        if (cs_rise) begin
          state_d  = IDLE;
          fbr_d    = 1'b0;
          bitcnt_d = '0;
          ferr_d   = (bitcnt_q != '0);
        end else if (sclk_rise) begin
          shift_d  = full_shift[SW-2:0];
          bitcnt_d = bitcnt_q + 1'b1;
          if (state_q == ADDR && bitcnt_q == ADDR_LAST) begin
            addr_d   = full_shift[AddressWidth-1:0];
            fbr_d    = 1'b1;
            bitcnt_d = '0;
            state_d  = DATA;
          end else if (state_q == DATA && bitcnt_q == DATA_LAST) begin
            wdata_d  = full_shift[DataWidth-1:0];
            strobe_d = 1'b1;
            bitcnt_d = '0;
          end
        end
      end
      default: begin
        state_d = WAIT_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state_q  <= WAIT_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      fbr_q    <= 1'b0;
      strobe_q <= 1'b0;
      step_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      fbr_q    <= fbr_d;
      strobe_q <= strobe_d;
      step_q   <= step_d;
      ferr_q   <= ferr_d;
    end
  end

  assign FirstByteReceived = fbr_q;
  assign FirstAddress      = addr_q;
  assign WriteData         = wdata_q;
  assign WriteStrobe       = strobe_q;
  assign AddressStep       = step_q;
  assign FrameError        = ferr_q;

`ifdef SPI_READBACK_EN
  logic [DataWidth-1:0] tx_q, tx_d;
  logic                 fbr_prev_q;
  logic                 unused_sclk;

  // The SCLK fall right after a byte boundary (bitcnt==0) must not shift, so the
  // freshly loaded MSB is still on MISO for the first rise of the next byte.
  always_comb begin
    tx_d = tx_q;
    if ((fbr_q && !fbr_prev_q) || step_q) begin
      tx_d = ReadData;
    end else if (state_q == DATA && sclk_fall && bitcnt_q != '0) begin
      tx_d = {tx_q[DataWidth-2:0], 1'b0};
    end
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      tx_q       <= '0;
      fbr_prev_q <= 1'b0;
    end else begin
      tx_q       <= tx_d;
      fbr_prev_q <= fbr_q;
    end
  end

  assign MISO        = (state_q == DATA) ? tx_q[DataWidth-1] : 1'b0;
  assign unused_sclk = sclk_sync;
`else
  logic unused_sclk;
  assign unused_sclk = ^{sclk_sync, sclk_fall};
`endif

endmodule

// File: tb/tb_spi_byte_framer.sv
// Directed self-checking bench for spi_byte_framer (also covers the SPI_READBACK_EN build).
module tb_spi_byte_framer;

  localparam int HALF = 50;        // half SCLK period; CLK period is 10
  localparam int GAP  = 4 * HALF;  // _CS high time between frames (2 SCLK periods)

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       fbr;
  logic [7:0] first_addr;
  logic [7:0] wdata;
  logic       wstrobe;
  logic       astep;
  logic       ferr;
  logic       miso;
  logic [7:0] read_data;

  spi_byte_framer dut (
    .CLK               (clk),
    ._RST              (rst_n),
    .SCLK              (sclk),
    .MOSI              (mosi),
    ._CS               (cs_n),
    .FirstByteReceived (fbr),
    .FirstAddress      (first_addr),
    .WriteData         (wdata),
    .WriteStrobe       (wstrobe),
    .AddressStep       (astep),
    .FrameError        (ferr)
`ifdef SPI_READBACK_EN
    ,
    .ReadData          (read_data),
    .MISO              (miso)
`endif
  );

`ifndef SPI_READBACK_EN
  assign miso = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks_total = 0;
  int checks_passed = 0;

  int         strobe_cnt;
  int         ferr_cnt;
  int         step_ok;
  int         step_bad;
  logic       strobe_prev;
  logic [7:0] wdata_log[$];
  logic [7:0] miso_byte;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      checks_passed++;
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic clear_counts();
    strobe_cnt = 0;
    ferr_cnt   = 0;
    step_ok    = 0;
    step_bad   = 0;
    wdata_log.delete();
  endtask

  function automatic logic [31:0] logged(input int i);
    return (wdata_log.size() > i) ? {24'h0, wdata_log[i]} : 32'hDEAD;
  endfunction

  // Pulse bookkeeping sampled on the falling CLK edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      strobe_prev = 1'b0;
    end else begin
      if (wstrobe) begin
        strobe_cnt++;
        wdata_log.push_back(wdata);
      end
      if (ferr) ferr_cnt++;
      if (astep) begin
        if (strobe_prev) step_ok++;
        else step_bad++;
      end else if (strobe_prev) begin
        step_bad++;
      end
      strobe_prev = wstrobe;
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #HALF;
      miso_byte = {miso_byte[6:0], miso};
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_end();
    #HALF;
    cs_n = 1'b1;
    #GAP;
  endtask

  initial begin
    rst_n     = 1'b0;
    cs_n      = 1'b1;
    sclk      = 1'b0;
    mosi      = 1'b0;
    read_data = 8'h81;
    miso_byte = 8'h00;
    clear_counts();
    #12;
    check_eq("reset_fbr",    {31'h0, fbr}, 32'h0);
    check_eq("reset_addr",   {24'h0, first_addr}, 32'h0);
    check_eq("reset_wdata",  {24'h0, wdata}, 32'h0);
    check_eq("reset_strobe", {31'h0, wstrobe}, 32'h0);
    check_eq("reset_step",   {31'h0, astep}, 32'h0);
    check_eq("reset_ferr",   {31'h0, ferr}, 32'h0);
    #18;
    rst_n = 1'b1;
    #200;

    // 1: address 0x05, data 0xA5 then 0x3C
    clear_counts();
    cs_begin();
    spi_bits(8'h05, 8);
    repeat (2) @(negedge clk);
    check_eq("t1_fbr_set",  {31'h0, fbr}, 32'h1);
    check_eq("t1_addr",     {24'h0, first_addr}, 32'h05);
    spi_bits(8'hA5, 8);
    spi_bits(8'h3C, 8);
    cs_end();
    check_eq("t1_strobes",  strobe_cnt, 32'd2);
    check_eq("t1_wdata0",   logged(0), 32'hA5);
    check_eq("t1_wdata1",   logged(1), 32'h3C);
    check_eq("t1_step_ok",  step_ok, 32'd2);
    check_eq("t1_step_bad", step_bad, 32'd0);
    check_eq("t1_ferr",     ferr_cnt, 32'd0);
    check_eq("t1_fbr_clr",  {31'h0, fbr}, 32'h0);

    // 2: address 0x10 plus 3 data bits, then _CS high
    clear_counts();
    cs_begin();
    spi_bits(8'h10, 8);
    spi_bits(8'hA0, 3);
    cs_end();
    check_eq("t2_ferr",    ferr_cnt, 32'd1);
    check_eq("t2_strobes", strobe_cnt, 32'd0);
    check_eq("t2_fbr",     {31'h0, fbr}, 32'h0);
    check_eq("t2_addr",    {24'h0, first_addr}, 32'h10);
    check_eq("t2_wdata",   {24'h0, wdata}, 32'h3C);

    // 3: address-only frame
    clear_counts();
    cs_begin();
    spi_bits(8'h22, 8);
    repeat (2) @(negedge clk);
    check_eq("t3_fbr_set", {31'h0, fbr}, 32'h1);
    cs_end();
    check_eq("t3_addr",    {24'h0, first_addr}, 32'h22);
    check_eq("t3_strobes", strobe_cnt, 32'd0);
    check_eq("t3_ferr",    ferr_cnt, 32'd0);
    check_eq("t3_fbr_clr", {31'h0, fbr}, 32'h0);

    // 4: reset in the middle of a data byte
    cs_begin();
    spi_bits(8'h33, 8);
    spi_bits(8'hA0, 4);
    rst_n = 1'b0;
    #3;
    check_eq("t4_rst_fbr",   {31'h0, fbr}, 32'h0);
    check_eq("t4_rst_addr",  {24'h0, first_addr}, 32'h0);
    check_eq("t4_rst_wdata", {24'h0, wdata}, 32'h0);
    #17;
    rst_n = 1'b1;
    clear_counts();
    spi_bits(8'h50, 4);
    spi_bits(8'hFF, 8);
    cs_end();
    check_eq("t4_tail_strobes", strobe_cnt, 32'd0);
    check_eq("t4_tail_ferr",    ferr_cnt, 32'd0);
    check_eq("t4_tail_addr",    {24'h0, first_addr}, 32'h0);
    clear_counts();
    cs_begin();
    spi_bits(8'h01, 8);
    spi_bits(8'h77, 8);
    cs_end();
    check_eq("t4_addr",    {24'h0, first_addr}, 32'h01);
    check_eq("t4_strobes", strobe_cnt, 32'd1);
    check_eq("t4_wdata",   logged(0), 32'h77);

    // 5: back-to-back frames with a 2-SCLK-period gap
    clear_counts();
    cs_begin();
    spi_bits(8'h0A, 8);
    spi_bits(8'h5A, 8);
    cs_end();
    cs_begin();
    spi_bits(8'h0B, 8);
    repeat (2) @(negedge clk);
    check_eq("t5_addr2",      {24'h0, first_addr}, 32'h0B);
    check_eq("t5_wdata_held", {24'h0, wdata}, 32'h5A);
    spi_bits(8'hC3, 8);
    cs_end();
    check_eq("t5_wdata_new",  {24'h0, wdata}, 32'hC3);
    check_eq("t5_strobes",    strobe_cnt, 32'd2);

`ifdef SPI_READBACK_EN
    // 6: readback of 0x81 over the first data byte
    read_data = 8'h81;
    cs_begin();
    spi_bits(8'h02, 8);
    miso_byte = 8'h00;
    spi_bits(8'h00, 8);
    cs_end();
    check_eq("t6_miso_byte", {24'h0, miso_byte}, 32'h81);
    check_eq("t6_miso_idle", {31'h0, miso}, 32'h0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
